zigzag_blok_sirala: RTL
=======================

// Module: zigzag_blok_sirala
// PURPOSE
//  Block/MCU sequencer in front of the zigzag normalizer. Receives (run,cat) symbols from the Huffman
//  decoder, tracks coefficient position inside each 8x8 block, closes blocks on EOB or position 64,
//  walks Y/Cb/Cr blocks of each MCU and MCUs of a frame, tells the Huffman decoder which table
//  (component, DC/AC) to use next, and forwards symbols to the normalizer through a 1-deep register.
// PARAMETERS
//  Y_BLOK   4   Y blocks per MCU (1..4)
//  CB_BLOK  1   Cb blocks per MCU (0..1)
//  CR_BLOK  1   Cr blocks per MCU (0..1)
//  MCU_BIT  16  width of MCU counter / mcu_sayisi_i
// PORTS
//  clk_i          in   1           clock
//  rstn_i         in   1           async active-low reset
//  baslat_i       in   1           start frame (1-cycle pulse)
//  mcu_sayisi_i   in   MCU_BIT     MCUs in frame, sampled on accepted baslat_i
//  hd_run_i       in   `RUN_BIT    run from Huffman decoder
//  hd_cat_i       in   `CAT_BIT    cat/value from Huffman decoder
//  hd_gecerli_i   in   1           upstream valid
//  hd_hazir_o     out  1           upstream ready
//  hd_ac_o        out  1           next symbol uses AC table (0 = DC)
//  hd_bilesen_o   out  2           next symbol component: 0 Y, 1 Cb, 2 Cr
//  nz_run_o       out  `RUN_BIT    run to normalizer
//  nz_cat_o       out  `CAT_BIT    cat to normalizer
//  nz_bilesen_o   out  2           component of forwarded symbol
//  nz_son_o       out  1           forwarded symbol closes its block
//  nz_gecerli_o   out  1           downstream valid
//  nz_hazir_i     in   1           downstream ready
//  tamam_o        out  1           1-cycle pulse: last block of frame delivered
//  hata_o         out  1           sticky: position overflow
// BEHAVIOUR
//  Reset: state BOSTA; pos=0, blok_idx=0, mcu=0; all outputs 0 (hd_bilesen_o=0, hd_ac_o=0).
//  States: BOSTA, DC, AC, HATA. hd_ac_o = (state==AC); hd_bilesen_o from blok_idx:
//   idx<Y_BLOK -> 0; idx<Y_BLOK+CB_BLOK -> 1; else 2.
//  hd_hazir_o = (state==DC||state==AC) && (!nz_gecerli_o || nz_hazir_i). Accept = hd_gecerli_i&&hd_hazir_o.
//  Accepted symbol lands in output regs next cycle (latency 1); full throughput when nz_hazir_i=1.
//  Output reg held stable while nz_gecerli_o && !nz_hazir_i; cleared on transfer with no new accept.
//  BOSTA: baslat_i && mcu_sayisi_i!=0 -> latch count, clear counters/hata_o -> DC. Count 0: ignored.
//   baslat_i in DC/AC ignored.
//  DC: accept -> forward as-is, pos=1, nz_son_o=0 -> AC.
//  AC (pos_new in 7 bits):
//   EOB (run 0,cat 0): forward, nz_son_o=1, block closes.
//   ZRL (run 15,cat 0): pos_new=pos+16. Other: pos_new=pos+run+1.
//   pos_new<64: forward, nz_son_o=0. pos_new==64: forward, nz_son_o=1, block closes.
//   pos_new>64: symbol dropped (not forwarded), hata_o=1 -> HATA.
//  Block close: pos=0, blok_idx++; at Y_BLOK+CB_BLOK+CR_BLOK-1 -> blok_idx=0, mcu++; next state DC.
//   Closing block of MCU mcu_sayisi-1: set son flag, state -> BOSTA, counters cleared.
//  tamam_o: pulses in the cycle the son-flagged symbol transfers (nz_gecerli_o&&nz_hazir_i); flag clears.
//  HATA: hd_hazir_o=0; pending output still drains; exits only via baslat_i (-> DC, counters and
//   hata_o cleared, new count latched) or reset.
//  Reset mid-frame: async, everything to reset values immediately; in-flight output lost.
// TESTING
//  1 Y=4,Cb=1,Cr=1, count=1; per block DC then EOB -> 12 transfers, nz_son_o on every 2nd,
//    hd_bilesen_o 0,0,0,0,1,2; tamam_o one pulse after 12th transfer; state BOSTA.
//  2 DC then AC run=0 x63 -> 63rd AC has nz_son_o=1, pos 64, next symbol uses DC table (hd_ac_o=0).
//  3 DC, ZRL x3 (pos 49), run=14 (pos 64) -> last forwarded with nz_son_o=1; no EOB needed.
//  4 DC, ZRL x3, run=15 cat=5 (pos 65) -> not forwarded, hata_o=1, hd_hazir_o=0; baslat_i clears.
//  5 nz_hazir_i=0 for 5 cycles with hd_gecerli_i=1 -> one symbol held stable, hd_hazir_o=0; release
//    -> symbols in order, none lost or duplicated.
//  6 rstn_i low mid-MCU -> outputs 0 immediately; post-reset baslat_i restarts at Y block 0.

Source files
------------

// File: rtl/zigzag_blok_sirala.sv
// Block/MCU sequencer in front of the zigzag normalizer.
// It tracks the coefficient position inside each 8x8 block and walks the
// Y/Cb/Cr blocks of every MCU and the MCUs of a frame. It also tells the
// Huffman decoder which table to use next, and forwards symbols through a
// single output register.

`ifndef RUN_BIT
`define RUN_BIT 4
`endif
`ifndef CAT_BIT
`define CAT_BIT 4
`endif

module zigzag_blok_sirala #(
  parameter int Y_BLOK  = 4,
  parameter int CB_BLOK = 1,
  parameter int CR_BLOK = 1,
  parameter int MCU_BIT = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 baslat_i,
  input  logic [MCU_BIT-1:0]   mcu_sayisi_i,
  input  logic [`RUN_BIT-1:0]  hd_run_i,
  input  logic [`CAT_BIT-1:0]  hd_cat_i,
  input  logic                 hd_gecerli_i,
  output logic                 hd_hazir_o,
  output logic                 hd_ac_o,
  output logic [1:0]           hd_bilesen_o,
  output logic [`RUN_BIT-1:0]  nz_run_o,
  output logic [`CAT_BIT-1:0]  nz_cat_o,
  output logic [1:0]           nz_bilesen_o,
  output logic                 nz_son_o,
  output logic                 nz_gecerli_o,
  input  logic                 nz_hazir_i,
  output logic                 tamam_o,
  output logic                 hata_o
);

  localparam int               TOPLAM_BLOK = Y_BLOK + CB_BLOK + CR_BLOK;
  localparam logic [2:0]       SON_BLOK    = 3'(TOPLAM_BLOK - 1);
  localparam logic [2:0]       Y_SINIR     = 3'(Y_BLOK);
  localparam logic [2:0]       CB_SINIR    = 3'(Y_BLOK + CB_BLOK);
  localparam logic [MCU_BIT-1:0] MCU_BIR   = MCU_BIT'(1);
  localparam logic [6:0]       BLOK_BOYU   = 7'd64;

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    DC    = 2'd1,
    AC    = 2'd2,
    HATA  = 2'd3
  } durum_t;

  durum_t               durum_q, durum_d;
  logic [6:0]           pos_q, pos_d;
  logic [2:0]           blok_q, blok_d;
  logic [MCU_BIT-1:0]   mcu_q, mcu_d;
  logic [MCU_BIT-1:0]   sayi_q, sayi_d;
  logic                 hata_q, hata_d;

  // Output register contents; kare_son marks the symbol that ends the frame.
  logic [`RUN_BIT-1:0]  run_q, run_d;
  logic [`CAT_BIT-1:0]  cat_q, cat_d;
  logic [1:0]           bil_q, bil_d;
  logic                 son_q, son_d;
  logic                 gecerli_q, gecerli_d;
  logic                 kare_son_q, kare_son_d;

  logic                 kabul;
  logic                 aktar;
  logic                 ileri;
  logic                 son_yeni;
  logic                 kare_son_yeni;
  logic                 blok_kapat;
  logic                 eob;
  logic                 zrl;
  logic [6:0]           pos_yeni;
  logic [1:0]           bilesen;

  // Component of the block currently being decoded.
  always_comb begin
    if (blok_q < Y_SINIR) begin
      bilesen = 2'd0;
    end else if (blok_q < CB_SINIR) begin
      bilesen = 2'd1;
    end else begin
      bilesen = 2'd2;
    end
  end

  assign hd_hazir_o   = ((durum_q == DC) || (durum_q == AC)) && (!gecerli_q || nz_hazir_i);
  assign hd_ac_o      = (durum_q == AC);
  assign hd_bilesen_o = bilesen;
  assign kabul        = hd_gecerli_i && hd_hazir_o;
  assign aktar        = gecerli_q && nz_hazir_i;

  assign nz_run_o     = run_q;
  assign nz_cat_o     = cat_q;
  assign nz_bilesen_o = bil_q;
  assign nz_son_o     = son_q;
  assign nz_gecerli_o = gecerli_q;
  assign tamam_o      = aktar && kare_son_q;
  assign hata_o       = hata_q;

  // Symbol classification and position advance; 7 bits hold up to 63+16.
  assign eob      = (hd_run_i == '0) && (hd_cat_i == '0);
  assign zrl      = (hd_run_i == `RUN_BIT'(15)) && (hd_cat_i == '0);
  assign pos_yeni = zrl ? (pos_q + 7'd16) : (pos_q + 7'(hd_run_i) + 7'd1);

  // Next-state, counter and output-register logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    durum_d       = durum_q;
    pos_d         = pos_q;
    blok_d        = blok_q;
    mcu_d         = mcu_q;
    sayi_d        = sayi_q;
    hata_d        = hata_q;
    run_d         = run_q;
    cat_d         = cat_q;
    bil_d         = bil_q;
    son_d         = son_q;
    gecerli_d     = aktar ? 1'b0 : gecerli_q;
    kare_son_d    = aktar ? 1'b0 : kare_son_q;
    ileri         = 1'b0;
    son_yeni      = 1'b0;
    kare_son_yeni = 1'b0;
    blok_kapat    = 1'b0;

    unique case (durum_q)
      BOSTA, HATA: begin
        // A zero-length frame is ignored; stay put.
        if (baslat_i && (mcu_sayisi_i != '0)) begin
          durum_d = DC;
          pos_d   = '0;
          blok_d  = '0;
          mcu_d   = '0;
          sayi_d  = mcu_sayisi_i;
          hata_d  = 1'b0;
        end
      end
      DC: begin
        if (kabul) begin
          ileri   = 1'b1;
          pos_d   = 7'd1;
          durum_d = AC;
        end
      end
      AC: begin
        if (kabul) begin
          if (eob) begin
            ileri      = 1'b1;
            son_yeni   = 1'b1;
            blok_kapat = 1'b1;
          end else if (pos_yeni < BLOK_BOYU) begin
            ileri = 1'b1;
            pos_d = pos_yeni;
          end else if (pos_yeni == BLOK_BOYU) begin
            ileri      = 1'b1;
            son_yeni   = 1'b1;
            blok_kapat = 1'b1;
          end else begin
            // Overflowing symbol is dropped; wait for a new frame start.
            hata_d  = 1'b1;
            durum_d = HATA;
          end
        end
      end
      default: durum_d = BOSTA;
    endcase

    // Block close: advance block/MCU, or finish the frame.
    if (blok_kapat) begin
      pos_d   = '0;
      durum_d = DC;
      if (blok_q == SON_BLOK) begin
        blok_d = '0;
        if (mcu_q == (sayi_q - MCU_BIR)) begin
          kare_son_yeni = 1'b1;
          mcu_d         = '0;
          durum_d       = BOSTA;
        end else begin
          mcu_d = mcu_q + MCU_BIR;
        end
      end else begin
        blok_d = blok_q + 3'd1;
      end
    end

    // Load the output register; hd_hazir_o guarantees it is free or draining.
    if (ileri) begin
      run_d      = hd_run_i;
      cat_d      = hd_cat_i;
      bil_d      = bilesen;
      son_d      = son_yeni;
      gecerli_d  = 1'b1;
      kare_son_d = kare_son_yeni;
    end
  end

  // State, counters and output register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      durum_q    <= BOSTA;
      pos_q      <= '0;
      blok_q     <= '0;
      mcu_q      <= '0;
      sayi_q     <= '0;
      hata_q     <= 1'b0;
      run_q      <= '0;
      cat_q      <= '0;
      bil_q      <= '0;
      son_q      <= 1'b0;
      gecerli_q  <= 1'b0;
      kare_son_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      durum_q    <= durum_d;
      pos_q      <= pos_d;
      blok_q     <= blok_d;
      mcu_q      <= mcu_d;
      sayi_q     <= sayi_d;
      hata_q     <= hata_d;
      run_q      <= run_d;
      cat_q      <= cat_d;
      bil_q      <= bil_d;
      son_q      <= son_d;
      gecerli_q  <= gecerli_d;
      kare_son_q <= kare_son_d;
    end
  end

endmodule
